// File: rtl/lottery_grant_arbiter_if.sv
// Request/grant bundle between the lottery manager side and the arbiter.
// The master modport drives requests, tickets and release; the slave modport is the arbiter.
interface lottery_grant_arbiter_if;
  logic [3:0] r;
  logic [3:0] s0;
  logic [4:0] s1;
  logic [5:0] s2;
  logic [5:0] s3;
  logic       rel;
  logic [3:0] g;
  logic [1:0] gnt_id;
  logic       busy;

  modport master (
    output r, s0, s1, s2, s3, rel,
    input  g, gnt_id, busy
  );

  modport slave (
    input  r, s0, s1, s2, s3, rel,
    output g, gnt_id, busy
  );
endinterface

// File: rtl/lottery_grant_arbiter.sv
// Lottery arbiter: an LFSR ticket picks a master from the cumulative ticket sums; the grant is held until released.
// Optional grant tenure limit is built when LOTTERY_TENURE_EN is defined.
module lottery_grant_arbiter #(
  parameter logic [5:0] SEED     = 6'h01,
  parameter int         MAX_DRAW = 63,
  parameter int         TENURE   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  lottery_grant_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAW  = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;

  // An all-zero LFSR would lock up, so a zero seed is replaced with 1.
  localparam logic [5:0]    SEED_SAFE = (SEED == 6'd0) ? 6'h01 : SEED;
  localparam int            CW        = (MAX_DRAW > 2) ? $clog2(MAX_DRAW) : 1;
  localparam logic [CW-1:0] LAST_DRAW = CW'(MAX_DRAW - 1);

  logic [1:0]    state_q, state_d;
  logic [5:0]    lfsr_q, lfsr_d;
  logic [CW-1:0] drawCnt_q, drawCnt_d;
  logic [3:0]    g_q, g_d;
  logic [1:0]    gntId_q, gntId_d;

  logic [5:0] s0x, s1x, ticket;
  logic [1:0] winner, fallback;
  logic       reqAny, ticketsAny, accept, tenureExpire;

  assign s0x        = {2'b00, bus.s0};
  assign s1x        = {1'b0, bus.s1};
  assign ticket     = lfsr_q - 6'd1;
  assign reqAny     = |bus.r;
  assign ticketsAny = (bus.s3 != 6'd0);
  assign lfsr_d     = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};

  always_comb begin
    winner = 2'd3;
    if (ticket < bus.s2) winner = 2'd2;
    if (ticket < s1x)    winner = 2'd1;
    if (ticket < s0x)    winner = 2'd0;
  end

  always_comb begin
    fallback = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.r[i]) fallback = 2'(i);
    end
  end

  assign accept = (lfsr_q <= bus.s3) && bus.r[winner];

`ifdef LOTTERY_TENURE_EN
  logic [5:0] tenure_q, tenure_d;

  // Counter sits at zero outside GRANT, so it is already cleared on grant entry.
  assign tenure_d     = (state_q == GRANT) ? tenure_q + 6'd1 : 6'd0;
  assign tenureExpire = (state_q == GRANT) && (tenure_q == 6'(TENURE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tenure_q <= 6'd0;
    else        tenure_q <= tenure_d;
  end
`else
  assign tenureExpire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    drawCnt_d = drawCnt_q;
    g_d       = g_q;
    gntId_d   = gntId_q;
    case (state_q)
      IDLE: begin
        g_d = 4'd0;
        if (reqAny && ticketsAny) begin
          state_d   = DRAW;
          drawCnt_d = '0;
        end
      end
      DRAW: begin
        if (!reqAny || !ticketsAny) begin
          state_d = IDLE;
        end else if (accept) begin
          state_d = GRANT;
          g_d     = 4'b0001 << winner;
          gntId_d = winner;
        end else if (drawCnt_q == LAST_DRAW) begin
          state_d = GRANT;
          g_d     = 4'b0001 << fallback;
          gntId_d = fallback;
        end else begin
          drawCnt_d = drawCnt_q + CW'(1);
        end
      end
      GRANT: begin
        // Release takes priority; any new request is re-evaluated from IDLE.
        if (bus.rel || !bus.r[gntId_q] || tenureExpire) begin
          state_d = IDLE;
          g_d     = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        g_d     = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_SAFE;
      drawCnt_q <= '0;
      g_q       <= 4'd0;
      gntId_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      drawCnt_q <= drawCnt_d;
      g_q       <= g_d;
      gntId_q   <= gntId_d;
    end
  end

  assign bus.g      = g_q;
  assign bus.gnt_id = gntId_q;
  assign bus.busy   = (state_q != IDLE);

endmodule
